aad_accum: RTL and testbench
============================

// Module: aad_accum
// PURPOSE
//   Accumulates the absolute difference |a-b| of two unsigned operands every clock cycle.
//   Building block for pooling-style Sum-of-Absolute-Differences (SAD) datapaths; top-level accumulator of the AAD design.
//   Output prev is the registered running sum.
// PARAMETERS
//   DATA_W  8  width of operands a, b (unsigned)
//   ACC_W   8  width of accumulator / prev; must be >= DATA_W
// PORTS
//   clk   in   1       rising-edge clock; sole clock domain
//   rst   in   1       synchronous, active-low reset (0 = reset), sampled on clk rising edge
//   a     in   DATA_W  unsigned operand A, sampled every rising edge
//   b     in   DATA_W  unsigned operand B, sampled every rising edge
//   prev  out  ACC_W   accumulated sum of |a-b|, driven directly from a register
// BEHAVIOUR
//   - Reset: on the rising edge with rst==0, acc <= 0. prev reads 0 from the next cycle onward.
//     Reset has priority over accumulation.
//   - Normal: on each rising edge with rst==1, acc <= acc + |a-b|. No enable and no handshake: every cycle accumulates.
//   - Latency: 1 cycle. Operands sampled at edge N appear in prev after edge N.
//   - |a-b| is combinational:
//       d = a-b, computed at DATA_W+1 bits.
//       If the borrow bit is set, the result is b-a; otherwise it is a-b.
//       Range 0..2^DATA_W-1. a==b gives 0. 0 vs 255 gives 255.
//   - Zero-extend |a-b| to ACC_W before the add.
//   - Overflow (default): wraps modulo 2^ACC_W. Carry-out is discarded; no flag.
//   - Reset asserted mid-accumulation: prev is 0 after that edge, and accumulation restarts from 0 on the first edge with rst==1.
//   - No X propagation: all state is reset-defined. No latches. No async logic.
// CONFIGURATION
//   Macro AAD_SATURATE_EN:
//   - defined: on overflow, acc clamps to 2^ACC_W-1 and stays there until reset.
//     Overflow is detected via the carry-out of the ACC_W+1-bit sum.
//   - undefined: wrap-around as above.
// STRUCTURE
//   - Package aad_pkg:
//       localparams DATA_W_DEF=8, ACC_W_DEF=8
//       typedef data_t  (logic [DATA_W-1:0])
//       typedef acc_t   (logic [ACC_W-1:0])
//       function absdiff(data_t a, data_t b) returning data_t
//   - Sub-module aad_absdiff (combinational, DATA_W param): ports a, b -> d.
//     Internally uses a Kogge-Stone prefix subtractor (a + ~b + 1).
//   - aad_accum: instantiates aad_absdiff, ACC_W adder (+ saturation mux under macro), acc register.
// TESTING
//   1 Reset: hold rst=0 for 2 edges with a=9, b=2 -> prev==0. Release rst=1 -> prev==7 after next edge.
//   2 Sequence from reset, one pair per cycle: (10,3),(20,30),(5,1),(100,100)
//     -> prev after each edge: 7, 17, 21, 21.
//   3 Wrap: continue case 2 with (0,255) -> prev==20 (276 mod 256).
//     With AAD_SATURATE_EN defined -> prev==255, and still 255 after a further (7,0).
//   4 Symmetry: (3,10) vs (10,3) from reset -> both give prev==7. (255,0) -> 255.
//   5 Mid-run reset: accumulate (50,0) for 3 cycles (prev==150), assert rst=0 for one edge -> prev==0.
//     Then (1,2) -> prev==1.
//   6 Random: 1000 random pairs vs reference model acc=(acc+|a-b|) mod 256 -> zero mismatches.

Source files
------------

// File: rtl/aad_pkg.sv
// Shared widths, types and a behavioural |a-b| helper for the AAD accumulator.
package aad_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 8;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ACC_W_DEF-1:0]  acc_t;

  function automatic data_t absdiff(data_t a, data_t b);
    return (a >= b) ? data_t'(a - b) : data_t'(b - a);
  endfunction
endpackage

// File: rtl/aad_absdiff.sv
// Combinational |a-b|: Kogge-Stone prefix subtractor (a + ~b + 1) whose carry-out
// (inverted) is the borrow selecting between a-b and b-a.
module aad_absdiff
  import aad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] d
);
  localparam int LVL = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0]      nb, p0, diff;
  logic [LVL:0][DATA_W-1:0]   gk;
  logic [LVL-1:0][DATA_W-1:0] pk;
  logic borrow;

  assign nb = ~b;
  assign p0 = a ^ nb;

  // Carry-in of 1 is folded into bit 0's generate term.
  assign gk[0] = {(a[DATA_W-1:1] & nb[DATA_W-1:1]), (a[0] | nb[0])};
  assign pk[0] = {p0[DATA_W-1:1], 1'b0};

  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_pre
        assign gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-(1<<l)]);
        if (l + 1 < LVL) begin : g_p
          assign pk[l+1][i] = pk[l][i] & pk[l][i-(1<<l)];
        end
      end else begin : g_pass
        assign gk[l+1][i] = gk[l][i] | (pk[l][i] & 1'b0);
        if (l + 1 < LVL) begin : g_p
          assign pk[l+1][i] = pk[l][i];
        end
      end
    end
  end

  assign diff[0] = ~p0[0];
  if (DATA_W > 1) begin : g_sum
    assign diff[DATA_W-1:1] = p0[DATA_W-1:1] ^ gk[LVL][DATA_W-2:0];
  end

  assign borrow = ~gk[LVL][DATA_W-1];
  assign d      = borrow ? (b - a) : diff;
endmodule

// File: rtl/aad_accum.sv
// Running sum of |a-b| every clock; prev is the accumulator register.
// Define AAD_SATURATE_EN to clamp at all-ones instead of wrapping.
module aad_accum
  import aad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  prev
);
  logic [DATA_W-1:0] ad;
  logic [ACC_W-1:0]  acc_q, acc_d;

  aad_absdiff #(.DATA_W(DATA_W)) u_absdiff (
    .a (a),
    .b (b),
    .d (ad)
  );

`ifdef AAD_SATURATE_EN
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(ad);
  // Once clamped, any further add either carries or adds zero, so it sticks.
  assign acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign acc_d = acc_q + ACC_W'(ad);
`endif

  always_ff @(posedge clk) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign prev = acc_q;
endmodule

// File: tb/tb_aad_accum.sv
// Scoreboard bench for aad_accum: driver pushes expected prev, monitor pops after each edge.
module tb_aad_accum;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] a = '0, b = '0;
  logic [ACC_W-1:0]  prev;

  aad_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .prev (prev)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    exp;
    string name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   model = 0;

  // Reference: plain integer arithmetic on the running sum.
  function automatic int model_next(int acc, bit r, int x, int y);
    int d, s;
    if (!r) return 0;
    d = (x > y) ? x - y : y - x;
    s = acc + d;
`ifdef AAD_SATURATE_EN
    if (s > (1 << ACC_W) - 1) s = (1 << ACC_W) - 1;
`else
    s = s % (1 << ACC_W);
`endif
    return s;
  endfunction

  // exp < 0 means "take the model's value".
  task automatic drive(input bit r, input int x, input int y, input int exp, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    a   = DATA_W'(x);
    b   = DATA_W'(y);
    model = model_next(model, r, x, y);
    e.exp  = (exp < 0) ? model : exp;
    e.name = nm;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (int'(prev) !== e.exp) begin
        bad++;
        $display("FAIL %s: prev=%0d expected=%0d", e.name, prev, e.exp);
      end
    end
  end

  initial begin
    int x, y;
    // 1: reset hold then release
    drive(0, 9, 2, 0, "reset0");
    drive(0, 9, 2, 0, "reset1");
    drive(1, 9, 2, 7, "release");
    // 2: directed sequence
    drive(0, 0, 0, 0, "seq_rst");
    drive(1, 10, 3, 7, "seq0");
    drive(1, 20, 30, 17, "seq1");
    drive(1, 5, 1, 21, "seq2");
    drive(1, 100, 100, 21, "seq3_equal");
    // 3: overflow boundary
`ifdef AAD_SATURATE_EN
    drive(1, 0, 255, 255, "sat");
    drive(1, 7, 0, 255, "sat_hold");
`else
    drive(1, 0, 255, 20, "wrap");
    drive(1, 7, 0, 27, "wrap_next");
`endif
    // 4: symmetry and full-scale difference
    drive(0, 0, 0, 0, "sym_rst0");
    drive(1, 3, 10, 7, "sym_ab");
    drive(0, 0, 0, 0, "sym_rst1");
    drive(1, 10, 3, 7, "sym_ba");
    drive(0, 0, 0, 0, "sym_rst2");
    drive(1, 255, 0, 255, "full_scale");
    // 5: reset in the middle of a run
    drive(0, 0, 0, 0, "mid_rst0");
    drive(1, 50, 0, 50, "mid0");
    drive(1, 50, 0, 100, "mid1");
    drive(1, 50, 0, 150, "mid2");
    drive(0, 50, 0, 0, "mid_rst");
    drive(1, 1, 2, 1, "mid_restart");
    // 6: random against the model
    drive(0, 0, 0, 0, "rnd_rst");
    for (int i = 0; i < 1000; i++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) drive(0, x, y, -1, "rnd_rst_mid");
      else                            drive(1, x, y, -1, "rnd");
    end
    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
